// File: rtl/pia_term_ctrl.sv
// Memory-mapped keyboard/terminal adapter: a 4-byte register window with a latched key
// register and a small FIFO that a three-state FSM drains to the terminal one char per tready pulse.
module pia_term_ctrl #(
  parameter logic [15:0] BASE  = 16'hD010,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        sel,
  input  logic [6:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic        tready,
  output logic        te,
  output logic [6:0]  ti
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_SETTLE
  } state_t;

  state_t          state, state_nxt;
  logic [6:0]      key;
  logic            key_avail;
  logic            ovf;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [6:0]      mem [DEPTH];

  logic [16:0]     rel;
  logic [1:0]      off;
  logic            rd, wr;
  logic            key_clr, ovf_clr, push, pop, push_ok, fifo_full, launch;
  logic [6:0]      key_in;
  logic [7:0]      rd_data;
  logic            unused_do7;

  assign unused_do7 = DO[7];

  // 17-bit subtraction so addresses below BASE wrap high and fall outside the window.
  assign rel = {1'b0, AB} - {1'b0, BASE};
  assign sel = (rel < 17'd4);
  assign off = rel[1:0];

  assign rd        = sel && !WE;
  assign wr        = sel && WE;
  assign key_clr   = (rd && off == 2'd0) || (wr && off == 2'd1);
  assign ovf_clr   = rd && off == 2'd3;
  assign push      = wr && off == 2'd2;
  assign fifo_full = (count == FULL_COUNT);
  assign pop       = (state == S_SEND);
  assign push_ok   = push && (!fifo_full || pop);
  assign launch    = (state == S_IDLE) && (state_nxt == S_SEND);
  assign te        = (state == S_SEND);

  // NOTE: every variable driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    key_in = kbd_data;
    if (kbd_data >= 7'd97 && kbd_data <= 7'd122) key_in = kbd_data - 7'd32;
  end

  always_comb begin
    rd_data = '0;
    case (off)
      2'd0: rd_data = {key_avail, key};
      2'd1: rd_data = {key_avail, 7'b0};
      2'd2: rd_data = {fifo_full, 7'b0};
      2'd3: rd_data = {7'b0, ovf};
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (count != '0 && tready) state_nxt = S_SEND;
      S_SEND:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      DI        <= '0;
      ti        <= '0;
      key       <= '0;
      key_avail <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (rd) DI <= rd_data;
      if (launch) ti <= mem[rd_ptr];

      // A new key beats a clearing access in the same cycle.
      if (kbd_valid) begin
        key       <= key_in;
        key_avail <= 1'b1;
      end else if (key_clr) begin
        key_avail <= 1'b0;
      end

      if (push && fifo_full && !pop) ovf <= 1'b1;
      else if (ovf_clr)              ovf <= 1'b0;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; emptiness is defined by count and the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= DO[6:0];
  end

endmodule

// File: tb/tb_pia_term_ctrl.sv
// Directed bench for pia_term_ctrl: register window, key folding, FIFO overflow and drain timing.
module tb_pia_term_ctrl;

  localparam logic [15:0] BASE = 16'hD010;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        sel;
  logic [6:0]  kbd_data;
  logic        kbd_valid;
  logic        tready;
  logic        te;
  logic [6:0]  ti;

  int errors = 0;
  int checks = 0;

  pia_term_ctrl #(.BASE(BASE), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .DI(DI), .sel(sel),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .tready(tready), .te(te), .ti(ti)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    AB = addr; DO = data; WE = 1'b1;
    step();
    WE = 1'b0; AB = 16'h0000; DO = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
    AB = addr; WE = 1'b0;
    step();
    data = DI;
    AB = 16'h0000;
  endtask

  task automatic key_pulse(input logic [6:0] code);
    kbd_data = code; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; AB = 16'h0000; DO = 8'h00; WE = 1'b0;
    kbd_data = '0; kbd_valid = 1'b0; tready = 1'b0;
    #3;
    checks++; if (DI !== 8'h00) begin errors++; $display("FAIL reset_di_now: got %h want 00", DI); end
    checks++; if (te !== 1'b0)  begin errors++; $display("FAIL reset_te_now: got %b want 0", te); end
    checks++; if (ti !== 7'h00) begin errors++; $display("FAIL reset_ti_now: got %h want 00", ti); end
    repeat (3) step();
    checks++; if (DI !== 8'h00 || te !== 1'b0) begin errors++; $display("FAIL reset_held: di=%h te=%b want 00/0", DI, te); end
    @(negedge clk); reset = 1'b0;
    step();
    bus_read(BASE + 16'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_fifo_full: got %h want 00", d); end
    bus_read(BASE + 16'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_key_avail: got %h want 00", d); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h want 00", d); end
  endtask

  task automatic test_sel();
    logic [15:0] addrs [4] = '{BASE - 16'd1, BASE, BASE + 16'd3, BASE + 16'd4};
    logic        exp   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      AB = addrs[i]; #1;
      checks++;
      if (sel !== exp[i]) begin errors++; $display("FAIL sel_%h: got %b want %b", addrs[i], sel, exp[i]); end
    end
    AB = 16'h0000;
  endtask

  task automatic test_basic_send();
    logic [7:0] d;
    bus_write(BASE + 16'd2, 8'h41);
    step(); step();
    checks++; if (te !== 1'b0) begin errors++; $display("FAIL basic_te_early: got %b want 0", te); end
    tready = 1'b1;
    step();
    tready = 1'b0;
    checks++; if (te !== 1'b1)  begin errors++; $display("FAIL basic_te: got %b want 1", te); end
    checks++; if (ti !== 7'h41) begin errors++; $display("FAIL basic_ti: got %h want 41", ti); end
    step();
    checks++; if (te !== 1'b0)  begin errors++; $display("FAIL basic_te_one_cycle: got %b want 0", te); end
    checks++; if (ti !== 7'h41) begin errors++; $display("FAIL basic_ti_hold: got %h want 41", ti); end
    step();
    bus_read(BASE + 16'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_fifo_full: got %h want 00", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [6:0] seen [$];
    for (int i = 0; i < 5; i++) bus_write(BASE + 16'd2, 8'h10 + 8'(i));
    bus_read(BASE + 16'd2, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL ovf_full_flag: got %h want 80", d); end
    bus_write(BASE + 16'd3, 8'hFF);
    bus_read(BASE + 16'd3, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL ovf_first_read: got %h want 01", d); end
    bus_read(BASE + 16'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovf_second_read: got %h want 00", d); end
    for (int i = 0; i < 5; i++) begin
      tready = 1'b1;
      step();
      tready = 1'b0;
      if (te === 1'b1) seen.push_back(ti);
      step(); step();
    end
    checks++;
    if (seen.size() != 4) begin errors++; $display("FAIL ovf_emit_count: got %0d want 4", seen.size()); end
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      checks++;
      if (seen[i] !== 7'h10 + 7'(i)) begin errors++; $display("FAIL ovf_emit_%0d: got %h want %h", i, seen[i], 7'h10 + 7'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    int pulse_at [$];
    logic [6:0] vals [$];
    bus_write(BASE + 16'd2, 8'h31);
    bus_write(BASE + 16'd2, 8'h32);
    bus_write(BASE + 16'd2, 8'h33);
    tready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (te === 1'b1) begin pulse_at.push_back(c); vals.push_back(ti); end
    end
    tready = 1'b0;
    checks++;
    if (pulse_at.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d want 3", pulse_at.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (pulse_at[i] - pulse_at[i-1] != 3) begin errors++; $display("FAIL b2b_period_%0d: got %0d want 3", i, pulse_at[i] - pulse_at[i-1]); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vals[i] !== 7'h31 + 7'(i)) begin errors++; $display("FAIL b2b_ti_%0d: got %h want %h", i, vals[i], 7'h31 + 7'(i)); end
      end
    end
    step(); step();
  endtask

  task automatic test_keyboard();
    logic [7:0] d;
    key_pulse(7'h61);
    bus_read(BASE, d);
    checks++; if (d !== 8'hC1) begin errors++; $display("FAIL kbd_fold_a: got %h want C1", d); end
    bus_read(BASE + 16'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL kbd_cleared: got %h want 00", d); end
    key_pulse(7'h7A);
    bus_read(BASE, d);
    checks++; if (d !== 8'hDA) begin errors++; $display("FAIL kbd_fold_z: got %h want DA", d); end
    key_pulse(7'h60);
    bus_read(BASE, d);
    checks++; if (d !== 8'hE0) begin errors++; $display("FAIL kbd_backtick: got %h want E0", d); end
    key_pulse(7'h7B);
    bus_write(BASE, 8'h00);
    bus_read(BASE + 16'd1, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL kbd_wr0_noeffect: got %h want 80", d); end
    bus_write(BASE + 16'd1, 8'hFF);
    bus_read(BASE + 16'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL kbd_wr1_clear: got %h want 00", d); end
    bus_read(BASE, d);
    checks++; if (d !== 8'h7B) begin errors++; $display("FAIL kbd_brace: got %h want 7B", d); end
    bus_read(BASE + 16'd4, d);
    checks++; if (d !== 8'h7B) begin errors++; $display("FAIL di_hold_above: got %h want 7B", d); end
    bus_read(BASE - 16'd1, d);
    checks++; if (d !== 8'h7B) begin errors++; $display("FAIL di_hold_below: got %h want 7B", d); end
  endtask

  task automatic test_kbd_collision();
    logic [7:0] d;
    key_pulse(7'h62);
    AB = BASE; WE = 1'b0; kbd_data = 7'h63; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0; AB = 16'h0000;
    checks++; if (DI !== 8'hC2) begin errors++; $display("FAIL coll_old_value: got %h want C2", DI); end
    bus_read(BASE + 16'd1, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL coll_avail_kept: got %h want 80", d); end
    bus_read(BASE, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL coll_new_key: got %h want C3", d); end
  endtask

  task automatic test_reset_in_send();
    logic [7:0] d;
    bus_write(BASE + 16'd2, 8'h58);
    bus_write(BASE + 16'd2, 8'h59);
    tready = 1'b1;
    step();
    tready = 1'b0;
    checks++; if (te !== 1'b1) begin errors++; $display("FAIL rst_send_entered: got %b want 1", te); end
    #2 reset = 1'b1;
    #1;
    checks++; if (te !== 1'b0)  begin errors++; $display("FAIL rst_send_te_async: got %b want 0", te); end
    checks++; if (ti !== 7'h00) begin errors++; $display("FAIL rst_send_ti: got %h want 00", ti); end
    @(negedge clk); reset = 1'b0;
    step();
    bus_read(BASE + 16'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_send_fifo: got %h want 00", d); end
    tready = 1'b1;
    step();
    tready = 1'b0;
    checks++; if (te !== 1'b0) begin errors++; $display("FAIL rst_send_empty_drain: got %b want 0", te); end
  endtask

  initial begin
    test_reset();
    test_sel();
    test_basic_send();
    test_overflow();
    test_back_to_back();
    test_keyboard();
    test_kbd_collision();
    test_reset_in_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pia_term_ctrl.md
PIA_TERM_CTRL -- requirements
Module: pia_term_ctrl

Interface
REQ-001 SHALL have parameter BASE, default 16'hD010, meaning the base address of a 4-byte register window (BASE..BASE+3).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the terminal output FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port AB  in  16  CPU address bus.
REQ-006 SHALL have port DO  in  8  CPU write data.
REQ-007 SHALL have port WE  in  1  CPU write enable; a cycle with WE=0 is a read of AB.
REQ-008 SHALL have port DI  out  8  registered read data for the window.
REQ-009 SHALL have port sel  out  1  combinational; high when AB is within BASE..BASE+3.
REQ-010 SHALL have port kbd_data  in  7  ASCII key code from the keyboard.
REQ-011 SHALL have port kbd_valid  in  1  single-cycle pulse; a new key is present on kbd_data.
REQ-012 SHALL have port tready  in  1  terminal ready pulse.
REQ-013 SHALL have port te  out  1  terminal write enable.
REQ-014 SHALL have port ti  out  7  terminal character.

Function
REQ-015 Register map:
- BASE+0 read: {key_avail, key[6:0]}; a read clears key_avail.
- BASE+1 read: {key_avail, 7'b0}; any write clears key_avail.
- BASE+2 write: push DO[6:0] to the FIFO. BASE+2 read: {fifo_full, 7'b0}.
- BASE+3 read: {7'b0, ovf}; a read clears ovf.
REQ-016 DI SHALL update one cycle after a read cycle. Reads outside the window SHALL hold DI unchanged.
REQ-017 kbd_valid SHALL load key<=kbd_data and set key_avail, overwriting any unread key.
REQ-018 kbd_valid in the same cycle as a clearing access: set SHALL win; DI SHALL return the old value.
REQ-019 Uppercase folding: kbd_data in 'a'..'z' (97..122) SHALL be stored minus 32.
REQ-020 FIFO count SHALL range 0..DEPTH. fifo_full SHALL equal (count==DEPTH).
REQ-021 A push when full with no pop in the same cycle SHALL drop the data and set sticky ovf. A push while full with a simultaneous pop SHALL be accepted.
REQ-022 Drain FSM states:
- IDLE -> SEND when count>0 and tready=1.
- SEND -> SETTLE.
- SETTLE -> IDLE.
REQ-023 In SEND, te SHALL be 1 for exactly one cycle, with ti = FIFO head; the pop occurs at the end of SEND.
REQ-024 te SHALL be 0 in all other states. ti SHALL hold the last sent value.
REQ-025 In SETTLE, tready SHALL be ignored; this guarantees at most one character per tready pulse.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH. Write-to-te latency from an empty FIFO: te asserts the cycle after the first tready seen after the push.
REQ-027 Writes to BASE+0 and BASE+3 SHALL have no effect.

Reset
REQ-028 On reset assertion, immediately and for its duration, outputs SHALL be: DI=0, te=0, ti=0, count=0, pointers=0, key=0, key_avail=0, ovf=0, FSM=IDLE.
REQ-029 Reset during SEND SHALL drop te the same instant and discard the FIFO contents.

Verification
REQ-030 Bench SHALL cover:
- Write 0x41 to BASE+2; pulse tready 3 cycles later -> te=1 for one cycle with ti=0x41; BASE+2 reads 0x00.
- Push 5 bytes with DEPTH=4 and tready=0 -> BASE+2 reads 0x80; BASE+3 reads 0x01, then 0x00 on a second read; only the first 4 bytes are later emitted, in order.
- Hold tready=1 continuously with 3 bytes queued -> te pulses exactly every 3 cycles; 3 pulses total.
- kbd_valid with 0x61 -> BASE+0 reads 0xC1, then BASE+1 reads 0x00.
- kbd_valid coincident with a BASE+0 read -> DI shows the old value; key_avail remains 1.
- Assert reset in the SEND cycle -> te=0 asynchronously; FIFO empty after release.
